// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants and instruction-type encodings.
package reorder_buffer_pkg;

    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned ROB_ADDR  = $clog2(ROB_DEPTH);
    localparam int unsigned REG_W     = 5;
    localparam int unsigned XLEN      = 32;

    typedef enum logic [1:0] {
        INSTR_ALU    = 2'd0,
        INSTR_BRANCH = 2'd1,
        INSTR_STORE  = 2'd2
    } instr_type_e;

    // Branch takes priority if the decoder ever flags both.
    function automatic instr_type_e decode_type(input logic is_br, input logic is_store);
        if (is_br) begin
            return INSTR_BRANCH;
        end else if (is_store) begin
            return INSTR_STORE;
        end
        return INSTR_ALU;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer with writeback bypass and branch-mispredict flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter  int unsigned RoB_DEPTH = ROB_DEPTH,
    localparam int unsigned RoB_addr  = $clog2(RoB_DEPTH)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    // issue
    input  logic                issue_valid,
    input  logic [REG_W-1:0]    issue_rd,
    input  logic                issue_is_br,
    input  logic                issue_is_store,
    input  logic                issue_pred_taken,
    input  logic [XLEN-1:0]     issue_alt_pc,
    output logic                rob_full,
    output logic [RoB_addr-1:0] rob_tail,
    // writeback
    input  logic                wb_valid,
    input  logic [RoB_addr-1:0] wb_robid,
    input  logic [XLEN-1:0]     wb_value,
    input  logic                wb_taken,
    // operand lookup
    input  logic [RoB_addr-1:0] q1_id,
    input  logic [RoB_addr-1:0] q2_id,
    output logic                q1_ready,
    output logic                q2_ready,
    output logic [XLEN-1:0]     q1_val,
    output logic [XLEN-1:0]     q2_val,
    // commit
    output logic                commit_valid,
    output logic [REG_W-1:0]    commit_regid,
    output logic [XLEN-1:0]     commit_value,
    output logic [RoB_addr-1:0] commit_robid,
    output logic                commit_store,
    output logic                rob_clear,
    output logic [XLEN-1:0]     redirect_pc
);

    localparam int unsigned CNT_W = RoB_addr + 1;

    // Per-field entry storage
    logic              r_busy   [RoB_DEPTH];
    logic              r_ready  [RoB_DEPTH];
    instr_type_e       r_type   [RoB_DEPTH];
    logic [REG_W-1:0]  r_rd     [RoB_DEPTH];
    logic              r_pred   [RoB_DEPTH];
    logic              r_taken  [RoB_DEPTH];
    logic [XLEN-1:0]   r_alt_pc [RoB_DEPTH];
    logic [XLEN-1:0]   r_value  [RoB_DEPTH];

    logic [RoB_addr-1:0] r_head;
    logic [RoB_addr-1:0] r_tail;
    logic [CNT_W-1:0]    r_count;

    logic                w_issue_fire;
    logic                w_commit_fire;
    logic                w_mispredict;
    logic                w_q1_bypass;
    logic                w_q2_bypass;
    logic [RoB_addr-1:0] w_head_next;
    logic [RoB_addr-1:0] w_tail_next;
    logic [CNT_W-1:0]    w_count_next;

    function automatic logic [RoB_addr-1:0] ptr_inc(input logic [RoB_addr-1:0] p);
        return (p == RoB_addr'(RoB_DEPTH - 1)) ? '0 : p + RoB_addr'(1);
    endfunction

    assign rob_full = (r_count == CNT_W'(RoB_DEPTH));
    assign rob_tail = r_tail;

    // Combinational operand lookup with same-cycle writeback bypass
    always_comb begin
        w_q1_bypass = wb_valid && (wb_robid == q1_id);
        w_q2_bypass = wb_valid && (wb_robid == q2_id);
        q1_ready    = r_ready[q1_id] || w_q1_bypass;
        q2_ready    = r_ready[q2_id] || w_q2_bypass;
        q1_val      = w_q1_bypass ? wb_value : r_value[q1_id];
        q2_val      = w_q2_bypass ? wb_value : r_value[q2_id];
    end

    // Issue/commit decisions and next pointer/count values
    always_comb begin
        w_issue_fire  = issue_valid && !rob_full && !rob_clear;
        w_commit_fire = r_busy[r_head] && r_ready[r_head] && !rob_clear;
        w_mispredict  = (r_type[r_head] == INSTR_BRANCH) && (r_taken[r_head] != r_pred[r_head]);
        w_head_next   = w_commit_fire ? ptr_inc(r_head) : r_head;
        w_tail_next   = w_issue_fire  ? ptr_inc(r_tail) : r_tail;
        w_count_next  = r_count;
        case ({w_issue_fire, w_commit_fire})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Entry storage, pointers and registered commit/flush outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(RoB_DEPTH); i++) begin
                r_busy[i]   <= 1'b0;
                r_ready[i]  <= 1'b0;
                r_type[i]   <= INSTR_ALU;
                r_rd[i]     <= '0;
                r_pred[i]   <= 1'b0;
                r_taken[i]  <= 1'b0;
                r_alt_pc[i] <= '0;
                r_value[i]  <= '0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            commit_valid <= 1'b0;
            commit_regid <= '0;
            commit_value <= '0;
            commit_robid <= '0;
            commit_store <= 1'b0;
            rob_clear    <= 1'b0;
            redirect_pc  <= '0;
        end else if (rdy_in) begin
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            rob_clear    <= 1'b0;
            if (rob_clear) begin
                // Flush cycle: drop everything, ignore issue and writeback
                for (int i = 0; i < int'(RoB_DEPTH); i++) begin
                    r_busy[i]  <= 1'b0;
                    r_ready[i] <= 1'b0;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (wb_valid && r_busy[wb_robid]) begin
                    r_ready[wb_robid] <= 1'b1;
                    r_value[wb_robid] <= wb_value;
                    r_taken[wb_robid] <= wb_taken;
                end
                if (w_issue_fire) begin
                    r_busy[r_tail]   <= 1'b1;
                    r_ready[r_tail]  <= issue_is_store && !issue_is_br;
                    r_type[r_tail]   <= decode_type(issue_is_br, issue_is_store);
                    r_rd[r_tail]     <= issue_rd;
                    r_pred[r_tail]   <= issue_pred_taken;
                    r_taken[r_tail]  <= 1'b0;
                    r_alt_pc[r_tail] <= issue_alt_pc;
                    r_value[r_tail]  <= '0;
                end
                if (w_commit_fire) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    commit_valid    <= 1'b1;
                    commit_robid    <= r_head;
                    commit_value    <= r_value[r_head];
                    commit_regid    <= (r_type[r_head] == INSTR_ALU) ? r_rd[r_head] : '0;
                    commit_store    <= (r_type[r_head] == INSTR_STORE);
                    if (w_mispredict) begin
                        rob_clear   <= 1'b1;
                        redirect_pc <= r_alt_pc[r_head];
                    end
                end
                r_head  <= w_head_next;
                r_tail  <= w_tail_next;
                r_count <= w_count_next;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b1;
    logic                rdy_in = 1'b1;
    logic                issue_valid = 1'b0;
    logic [REG_W-1:0]    issue_rd = '0;
    logic                issue_is_br = 1'b0;
    logic                issue_is_store = 1'b0;
    logic                issue_pred_taken = 1'b0;
    logic [XLEN-1:0]     issue_alt_pc = '0;
    logic                rob_full;
    logic [ROB_ADDR-1:0] rob_tail;
    logic                wb_valid = 1'b0;
    logic [ROB_ADDR-1:0] wb_robid = '0;
    logic [XLEN-1:0]     wb_value = '0;
    logic                wb_taken = 1'b0;
    logic [ROB_ADDR-1:0] q1_id = '0;
    logic [ROB_ADDR-1:0] q2_id = '0;
    logic                q1_ready, q2_ready;
    logic [XLEN-1:0]     q1_val, q2_val;
    logic                commit_valid;
    logic [REG_W-1:0]    commit_regid;
    logic [XLEN-1:0]     commit_value;
    logic [ROB_ADDR-1:0] commit_robid;
    logic                commit_store;
    logic                rob_clear;
    logic [XLEN-1:0]     redirect_pc;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.RoB_DEPTH(ROB_DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
        .issue_is_store(issue_is_store), .issue_pred_taken(issue_pred_taken),
        .issue_alt_pc(issue_alt_pc), .rob_full(rob_full), .rob_tail(rob_tail),
        .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_value(wb_value), .wb_taken(wb_taken),
        .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .commit_valid(commit_valid), .commit_regid(commit_regid), .commit_value(commit_value),
        .commit_robid(commit_robid), .commit_store(commit_store),
        .rob_clear(rob_clear), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0; issue_is_br = 1'b0; issue_is_store = 1'b0;
        issue_pred_taken = 1'b0; issue_alt_pc = '0;
        wb_valid = 1'b0; wb_robid = '0; wb_value = '0; wb_taken = 1'b0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic br, input logic st,
                             input logic pred, input logic [31:0] alt);
        issue_valid = 1'b1; issue_rd = rd; issue_is_br = br; issue_is_store = st;
        issue_pred_taken = pred; issue_alt_pc = alt;
    endtask

    task automatic set_wb(input logic [ROB_ADDR-1:0] id, input logic [31:0] val, input logic tk);
        wb_valid = 1'b1; wb_robid = id; wb_value = val; wb_taken = tk;
    endtask

    // Mid-operation reset: state must clear before any clock edge
    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b1;
        #1;
        chk("async_rst_count", 32'(dut.r_count), 32'd0);
        chk("async_rst_tail", 32'(rob_tail), 32'd0);
        step();
        rst_in = 1'b0;
        step();
    endtask

    initial begin
        // Power-on reset
        idle_inputs();
        step();
        step();
        chk("rst_tail", 32'(rob_tail), 32'd0);
        chk("rst_full", 32'(rob_full), 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_commit_store", 32'(commit_store), 32'd0);
        chk("rst_clear", 32'(rob_clear), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_commit_value", commit_value, 32'd0);
        rst_in = 1'b0;
        step();

        // Single issue
        set_issue(5'd5, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("t1_tag_before", 32'(rob_tail), 32'd0);
        step();
        idle_inputs();
        chk("t1_tag_after", 32'(rob_tail), 32'd1);
        chk("t1_full", 32'(rob_full), 32'd0);
        chk("t1_count", 32'(dut.r_count), 32'd1);

        // Global enable low freezes state
        rdy_in = 1'b0;
        set_issue(5'd6, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        chk("rdy_hold_tail", 32'(rob_tail), 32'd1);
        rdy_in = 1'b1;
        idle_inputs();

        // Fill the buffer, ninth issue rejected, tail wraps
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_issue(5'(i + 1), 1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end
        chk("fill_full", 32'(rob_full), 32'd1);
        chk("fill_tail_wrap", 32'(rob_tail), 32'd0);
        set_issue(5'd20, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        idle_inputs();
        chk("fill_9th_tail", 32'(rob_tail), 32'd0);
        chk("fill_9th_count", 32'(dut.r_count), 32'd8);
        chk("fill_no_commit", 32'(commit_valid), 32'd0);

        // Full + head ready + issue: commit proceeds, issue rejected then accepted
        set_wb(3'd0, 32'h55, 1'b0);
        step();
        idle_inputs();
        chk("full_wb_no_commit_yet", 32'(commit_valid), 32'd0);
        set_issue(5'd9, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        chk("full_commit_valid", 32'(commit_valid), 32'd1);
        chk("full_commit_robid", 32'(commit_robid), 32'd0);
        chk("full_commit_regid", 32'(commit_regid), 32'd1);
        chk("full_commit_value", commit_value, 32'h55);
        chk("full_issue_rejected", 32'(rob_tail), 32'd0);
        chk("full_freed", 32'(rob_full), 32'd0);
        step();
        idle_inputs();
        chk("full_issue_accepted", 32'(rob_tail), 32'd1);
        chk("full_again", 32'(rob_full), 32'd1);
        chk("full_commit_pulse", 32'(commit_valid), 32'd0);
        chk("full_value_hold", commit_value, 32'h55);

        // Out-of-order writeback, in-order commit, issue alongside commit
        do_reset();
        set_issue(5'd3, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        set_issue(5'd4, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        idle_inputs();
        set_wb(3'd1, 32'h22, 1'b0);
        step();
        chk("ooo_no_commit1", 32'(commit_valid), 32'd0);
        set_wb(3'd0, 32'h11, 1'b0);
        step();
        idle_inputs();
        chk("ooo_no_commit0", 32'(commit_valid), 32'd0);
        set_issue(5'd8, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        idle_inputs();
        chk("ooo_c0_valid", 32'(commit_valid), 32'd1);
        chk("ooo_c0_regid", 32'(commit_regid), 32'd3);
        chk("ooo_c0_value", commit_value, 32'h11);
        chk("ooo_c0_robid", 32'(commit_robid), 32'd0);
        chk("ooo_c0_count", 32'(dut.r_count), 32'd2);
        chk("ooo_c0_tail", 32'(rob_tail), 32'd3);
        step();
        chk("ooo_c1_valid", 32'(commit_valid), 32'd1);
        chk("ooo_c1_regid", 32'(commit_regid), 32'd4);
        chk("ooo_c1_value", commit_value, 32'h22);
        chk("ooo_c1_robid", 32'(commit_robid), 32'd1);
        chk("ooo_c1_count", 32'(dut.r_count), 32'd1);
        step();
        chk("ooo_c2_none", 32'(commit_valid), 32'd0);

        // Lookup with bypass
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(5'(i + 10), 1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end
        idle_inputs();
        q1_id = 3'd2;
        q2_id = 3'd1;
        set_wb(3'd2, 32'hABCD, 1'b0);
        #1;
        chk("byp_q1_ready", 32'(q1_ready), 32'd1);
        chk("byp_q1_val", q1_val, 32'hABCD);
        chk("byp_q2_ready", 32'(q2_ready), 32'd0);
        step();
        idle_inputs();
        #1;
        chk("stored_q1_ready", 32'(q1_ready), 32'd1);
        chk("stored_q1_val", q1_val, 32'hABCD);

        // Mispredicted branch flushes younger entries
        do_reset();
        set_issue(5'd0, 1'b1, 1'b0, 1'b0, 32'h1000);
        step();
        set_issue(5'd6, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        set_issue(5'd7, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        idle_inputs();
        set_wb(3'd0, 32'd0, 1'b1);
        step();
        idle_inputs();
        step();
        chk("br_commit_valid", 32'(commit_valid), 32'd1);
        chk("br_commit_regid", 32'(commit_regid), 32'd0);
        chk("br_clear", 32'(rob_clear), 32'd1);
        chk("br_redirect", redirect_pc, 32'h1000);
        set_issue(5'd12, 1'b0, 1'b0, 1'b0, 32'd0);
        set_wb(3'd1, 32'h99, 1'b0);
        step();
        idle_inputs();
        chk("br_clear_pulse", 32'(rob_clear), 32'd0);
        chk("br_no_commit", 32'(commit_valid), 32'd0);
        chk("br_count_zero", 32'(dut.r_count), 32'd0);
        chk("br_tail_zero", 32'(rob_tail), 32'd0);
        chk("br_redirect_hold", redirect_pc, 32'h1000);
        set_issue(5'd13, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        idle_inputs();
        chk("br_next_tag", 32'(rob_tail), 32'd1);
        chk("br_next_count", 32'(dut.r_count), 32'd1);

        // Store retires immediately; correctly predicted branch does not flush
        do_reset();
        set_issue(5'd9, 1'b0, 1'b1, 1'b0, 32'd0);
        step();
        set_issue(5'd0, 1'b1, 1'b0, 1'b1, 32'h2000);
        step();
        idle_inputs();
        chk("st_commit_valid", 32'(commit_valid), 32'd1);
        chk("st_commit_store", 32'(commit_store), 32'd1);
        chk("st_commit_regid", 32'(commit_regid), 32'd0);
        set_wb(3'd1, 32'd0, 1'b1);
        step();
        idle_inputs();
        chk("st_store_pulse", 32'(commit_store), 32'd0);
        step();
        chk("okbr_commit_valid", 32'(commit_valid), 32'd1);
        chk("okbr_commit_robid", 32'(commit_robid), 32'd1);
        chk("okbr_no_clear", 32'(rob_clear), 32'd0);
        chk("okbr_redirect", redirect_pc, 32'd0);
        step();
        chk("okbr_empty", 32'(dut.r_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
